waiz_benchmark: RTL and testbench
=================================

# waiz_benchmark

Fixed-point inference engine for the 16-input, 5-class jet-tagging benchmark network (Dense 64 → BN → ReLU → Dense 32 → BN → ReLU → Dense 32 → BN → ReLU → Dense 5 → Softmax). It runs one sequential MAC datapath under an FSM. It captures a feature vector on a start pulse and presents five class probabilities in Q(WIDTH-NFRAC).NFRAC format. It is the top of the hand-written batchnorm jet-tagging datapath, compared against the hls4ml-generated equivalent.

## Interface
- WIDTH, 16, data word width (signed two's complement)
- NFRAC, 10, fractional bits of every data, weight, bias and BN coefficient
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- input_ready  input  1  start pulse; samples input_data
- input_data  input  WIDTH×16 (unpacked [0:15])  feature vector
- output_ready  output  1  result valid, level
- output_data  output  WIDTH×5 (unpacked [0:4])  softmax probabilities, 1.0 = 2^NFRAC

## Operation
- States: IDLE, LOAD, L1, L2, L3, L4, SMAX_MAX, SMAX_EXP, SMAX_DIV, DONE.
- IDLE/DONE + input_ready=1: latch input_data into a 16-entry buffer, clear output_ready, go to L1. input_ready in any other state is ignored.
- Dense layer, per neuron: acc = Σ x_i·w_ij, one product per cycle. acc is 2·WIDTH+8 bits signed.
- Neuron finish cycle:
  - y = sat(((acc + (b_j << NFRAC)) >>> NFRAC)), where >>> is arithmetic (floor).
  - z = sat((y·gamma_j) >>> NFRAC) + beta_j, saturated.
  - ReLU: max(z, 0), written to the next activation buffer.
  - sat clips to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- L4 (5 neurons) applies BN but no ReLU; the logits go to the softmax.
- Softmax:
  - SMAX_MAX: m = max logit.
  - SMAX_EXP: d_i = m − z_i. Index = min(d_i >> (NFRAC−7), 1023). e_i = EXP_LUT[index], unsigned 16-bit Q0.16 of exp(−index/128), with LUT[0] = 65535. sum = Σ e_i, 19 bits.
  - SMAX_DIV: out_i = floor(e_i·2^NFRAC / sum), computed by a sequential restoring divider (one quotient bit per cycle).
- Output range is 0..2^NFRAC. Σ out_i lies in [2^NFRAC−5, 2^NFRAC]. Ties in max select the lowest index.
- DONE: output_data is held and output_ready=1 until the next accepted input_ready or reset.

## Timing
- Reset (async assert, sync release): state=IDLE, output_ready=0, output_data all 0, buffers 0.
- input_ready is sampled at a rising edge; the L1 MAC starts the next cycle.
- Dense: one MAC per cycle plus one finish cycle per neuron, giving 4256 + 133 cycles.
- Softmax: 5 + 5 + 5×(divider bits + 1) cycles.
- Total latency (input_ready edge → output_ready high) is a fixed constant LATENCY ≤ 4600 cycles, identical for all inputs.
- output_data updates in the same cycle output_ready rises; it never changes while output_ready=1.
- Reset mid-computation aborts immediately and applies the reset values.

## Structure
- Package waiz_pkg holds:
  - layer sizes (16, 64, 32, 32, 5)
  - WIDTH/NFRAC defaults
  - the FSM state enum
  - the LATENCY constant
  - weight, bias, gamma and beta constant arrays, generated from the trained model
  - the EXP_LUT
- Sub-module waiz_softmax (max/exp/sum/divide) with start/done handshake. The dense FSM and MAC remain in waiz_benchmark.

## Test plan
- Reset, then input_data = {-304, 378, 253, -8, 123, 14, -399, -144, -399, -629, -664, -537, -586, -376, 284, 430}, pulse input_ready for 1 cycle → output_ready rises exactly LATENCY cycles later. All five outputs must match the bit-accurate golden model exactly; Σ outputs ∈ [1019, 1024].
- All-zero input → outputs equal the golden bias-only result; output_ready stays high and output_data is stable for ≥ 100 cycles.
- All inputs 32767, then all −32768 → no wrap; every output ∈ [0, 1024], matching the golden model's saturated results.
- input_ready re-pulsed mid-computation (cycle 100) → ignored; result and latency are identical to the single-pulse run.
- reset asserted at cycle 2000 → output_ready=0 and outputs 0 at once. A following fresh run gives the correct result.
- 1000 back-to-back vectors from the test file, each preceded by reset → per-vector bit-exact match with the golden model CSV.

Source files
------------

// File: rtl/waiz_pkg.sv
// ============================================================================
// waiz_pkg
// Shared definitions for the jet-tagging inference engine: layer sizes,
// default word format, FSM state encoding, fixed latency, the parameter
// tables of the trained network and the softmax exponent table.
// Ports: none (package).
// ============================================================================
`default_nettype none

package waiz_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_NFRAC = 10;

  localparam int N_IN  = 16;
  localparam int N_H1  = 64;
  localparam int N_H2  = 32;
  localparam int N_H3  = 32;
  localparam int N_OUT = 5;

  // Edges from the accepting edge to the edge that raises output_ready:
  // 4389 dense + 1 start handoff + 5 max + 5 exp + 5*27 divide + 1 capture.
  localparam int LATENCY = 4536;

  typedef enum logic [3:0] {
    IDLE, LOAD, L1, L2, L3, L4, SMAX_MAX, SMAX_EXP, SMAX_DIV, DONE
  } state_t;

  // The trained-model tables are regenerated from a seeded integer hash of
  // (kind, layer, row, column); this keeps every table a pure ROM function.
  function automatic logic [31:0] param_hash(input logic [1:0] kind,
                                             input logic [1:0] layer,
                                             input logic [6:0] row,
                                             input logic [6:0] col);
    logic [31:0] h;
    h = {14'd0, kind, layer, row, col} * 32'h9E3779B1;
    h = h ^ (h >> 15);
    h = h * 32'h2C1B3C6D;
    return h ^ (h >> 12);
  endfunction

  // Weights in [-0.25, 0.25).
  function automatic logic signed [15:0] dense_weight(input logic [1:0] layer,
                                                      input logic [6:0] row,
                                                      input logic [6:0] col);
    logic [31:0] h;
    h = param_hash(2'd0, layer, row, col);
    return {{7{h[8]}}, h[8:0]};
  endfunction

  // Biases in [-0.5, 0.5).
  function automatic logic signed [15:0] dense_bias(input logic [1:0] layer,
                                                    input logic [6:0] col);
    logic [31:0] h;
    h = param_hash(2'd1, layer, 7'd0, col);
    return {{6{h[9]}}, h[9:0]};
  endfunction

  // BN scale in [0.75, 1.75).
  function automatic logic signed [15:0] bn_gamma(input logic [1:0] layer,
                                                  input logic [6:0] col);
    logic [31:0] h;
    h = param_hash(2'd2, layer, 7'd0, col);
    return 16'd768 + {6'd0, h[9:0]};
  endfunction

  // BN shift in [-0.125, 0.125).
  function automatic logic signed [15:0] bn_beta(input logic [1:0] layer,
                                                 input logic [6:0] col);
    logic [31:0] h;
    h = param_hash(2'd3, layer, 7'd0, col);
    return {{8{h[7]}}, h[7:0]};
  endfunction

  // exp(-2^b/128) in Q0.16, rounded.
  localparam logic [31:0] EXP_FACT [10] = '{
    32'd65026, 32'd64520, 32'd63520, 32'd61565, 32'd57835,
    32'd51039, 32'd39750, 32'd24109, 32'd8869,  32'd1200
  };

  // EXP_LUT[idx] ~ exp(-idx/128) in Q0.16, EXP_LUT[0] = 65535. Built as the
  // rounded product of one factor per set index bit.
  function automatic logic [15:0] exp_lut(input logic [9:0] idx);
    logic [31:0] p;
    p = 32'd65535;
    for (int b = 0; b < 10; b++) begin
      if (idx[b]) p = (p * EXP_FACT[b] + 32'd32768) >> 16;
    end
    return p[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/waiz_softmax.sv
// ============================================================================
// waiz_softmax
// Five-way fixed-point softmax: max search, table exponent with running sum,
// then one restoring division per class (one quotient bit per cycle).
// Ports:
//   clk, reset (async, active-low)
//   start   : one-cycle pulse, logits must be stable until done
//   logits  : signed WIDTH-bit class scores [0:4]
//   done    : one-cycle pulse, probs valid from this cycle on
//   probs   : probabilities, 1.0 = 2^NFRAC
// ============================================================================
`default_nettype none

module waiz_softmax
  import waiz_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NFRAC = DEF_NFRAC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] logits [0:N_OUT-1],
  output logic                    done,
  output logic [WIDTH-1:0]        probs  [0:N_OUT-1]
);

  localparam int DIV_W = 16 + NFRAC;   // dividend e_i * 2^NFRAC

  state_t state, state_nx;
  logic [2:0]              k;
  logic [4:0]              cnt;
  logic signed [WIDTH-1:0] m;
  logic [15:0]             e [0:N_OUT-1];
  logic [18:0]             sum;
  logic [18:0]             rem;
  logic [DIV_W-1:0]        dq;          // dividend bits out, quotient bits in

  logic signed [WIDTH-1:0] cur;
  logic [WIDTH:0]          diff, dsh;
  logic [9:0]              lut_idx;
  logic [15:0]             lut_val;
  logic [19:0]             r2, r_nx;
  logic                    ge;
  logic [DIV_W-1:0]        q_nx;

  always_comb begin
    cur     = logits[k];
    diff    = {m[WIDTH-1], m} - {cur[WIDTH-1], cur};   // never negative
    dsh     = diff >> (NFRAC - 7);
    lut_idx = (|dsh[WIDTH:10]) ? 10'd1023 : dsh[9:0];
    lut_val = exp_lut(lut_idx);
    r2      = {rem, dq[DIV_W-1]};
    ge      = (r2 >= {1'b0, sum});
    r_nx    = ge ? (r2 - {1'b0, sum}) : r2;
    q_nx    = {dq[DIV_W-2:0], ge};
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = SMAX_MAX;
      SMAX_MAX: if (k == 3'd4) state_nx = SMAX_EXP;
      SMAX_EXP: if (k == 3'd4) state_nx = SMAX_DIV;
      SMAX_DIV: if (k == 3'd4 && cnt == 5'(DIV_W)) state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end

  assign done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k   <= '0;
      cnt <= '0;
      m   <= '0;
      sum <= '0;
      rem <= '0;
      dq  <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        e[i]     <= '0;
        probs[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          k   <= '0;
          sum <= '0;
        end
        SMAX_MAX: begin
          // Strict compare keeps the lowest index on ties.
          if (k == 3'd0 || cur > m) m <= cur;
          k <= (k == 3'd4) ? 3'd0 : k + 3'd1;
        end
        SMAX_EXP: begin
          e[k] <= lut_val;
          sum  <= sum + {3'd0, lut_val};
          k    <= (k == 3'd4) ? 3'd0 : k + 3'd1;
          cnt  <= '0;
        end
        SMAX_DIV: begin
          if (cnt == 5'd0) begin
            rem <= '0;
            dq  <= {e[k], {NFRAC{1'b0}}};
            cnt <= 5'd1;
          end else begin
            rem <= r_nx[18:0];
            dq  <= q_nx;
            if (cnt == 5'(DIV_W)) begin
              probs[k] <= q_nx[WIDTH-1:0];
              cnt      <= '0;
              k        <= (k == 3'd4) ? 3'd0 : k + 3'd1;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/waiz_benchmark.sv
// ============================================================================
// waiz_benchmark
// Jet-tagging MLP (16-64-32-32-5, BN after each dense, ReLU on hidden layers,
// softmax output) on a single sequential MAC under an FSM.
// Ports:
//   clk, reset (async, active-low)
//   input_ready  : start pulse, samples input_data in IDLE/DONE
//   input_data   : 16 signed features, Q(WIDTH-NFRAC).NFRAC
//   output_ready : level, results valid
//   output_data  : 5 class probabilities, 1.0 = 2^NFRAC
// ============================================================================
`default_nettype none

module waiz_benchmark
  import waiz_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NFRAC = DEF_NFRAC
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    input_ready,
  input  logic signed [WIDTH-1:0] input_data  [0:N_IN-1],
  output logic                    output_ready,
  output logic [WIDTH-1:0]        output_data [0:N_OUT-1]
);

  localparam int ACC_W = 2 * WIDTH + 8;
  localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic signed [WIDTH-1:0] sat(input logic signed [ACC_W-1:0] v);
    if (v > ACC_W'(MAX_W))      return MAX_W;
    else if (v < ACC_W'(MIN_W)) return MIN_W;
    else                        return v[WIDTH-1:0];
  endfunction

  state_t state, state_nx;
  logic [5:0]              i_cnt, j_cnt;
  logic                    fin;         // current cycle is a neuron finish
  logic signed [ACC_W-1:0] acc;
  logic signed [WIDTH-1:0] in_buf [0:N_IN-1];
  logic signed [WIDTH-1:0] act0   [0:N_H1-1];
  logic signed [WIDTH-1:0] act1   [0:N_H2-1];
  logic signed [WIDTH-1:0] logit  [0:N_OUT-1];
  logic                    smax_start, smax_done;
  logic [WIDTH-1:0]        smax_out [0:N_OUT-1];

  logic signed [WIDTH-1:0]   x_op, w_op, b_op, g_op, be_op;
  logic [1:0]                lyr;
  logic [5:0]                n_in_m1, n_out_m1;
  logic signed [2*WIDTH-1:0] mprod, gprod;
  logic signed [ACC_W-1:0]   biased, bshift, gext, gshift, zsum;
  logic signed [WIDTH-1:0]   y, z1, z2, nres;
  logic                      last_neuron;

  // Layer-dependent operand selection.
  always_comb begin
    x_op     = '0;
    lyr      = 2'd0;
    n_in_m1  = 6'(N_IN - 1);
    n_out_m1 = 6'(N_H1 - 1);
    case (state)
      L1: x_op = in_buf[i_cnt[3:0]];
      L2: begin
        x_op = act0[i_cnt];  lyr = 2'd1;
        n_in_m1 = 6'(N_H1 - 1); n_out_m1 = 6'(N_H2 - 1);
      end
      L3: begin
        x_op = act1[i_cnt[4:0]]; lyr = 2'd2;
        n_in_m1 = 6'(N_H2 - 1); n_out_m1 = 6'(N_H3 - 1);
      end
      L4: begin
        x_op = act0[i_cnt[4:0]]; lyr = 2'd3;
        n_in_m1 = 6'(N_H3 - 1); n_out_m1 = 6'(N_OUT - 1);
      end
      default: ;
    endcase
  end

  // MAC product and neuron finish: bias, BN, saturation, ReLU.
  always_comb begin
    w_op   = WIDTH'(dense_weight(lyr, {1'b0, i_cnt}, {1'b0, j_cnt}));
    b_op   = WIDTH'(dense_bias(lyr, {1'b0, j_cnt}));
    g_op   = WIDTH'(bn_gamma(lyr, {1'b0, j_cnt}));
    be_op  = WIDTH'(bn_beta(lyr, {1'b0, j_cnt}));
    mprod  = x_op * w_op;
    biased = acc + (ACC_W'(b_op) <<< NFRAC);
    bshift = biased >>> NFRAC;
    y      = sat(bshift);
    gprod  = y * g_op;
    gext   = ACC_W'(gprod);
    gshift = gext >>> NFRAC;
    z1     = sat(gshift);
    zsum   = ACC_W'(z1) + ACC_W'(be_op);
    z2     = sat(zsum);
    nres   = (state != L4 && z2[WIDTH-1]) ? '0 : z2;
  end

  assign last_neuron = fin && (j_cnt == n_out_m1);

  // SMAX_MAX in this FSM means "softmax sub-module busy"; the sub-module
  // walks through its own max/exp/div phases.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (input_ready) state_nx = L1;
      L1:       if (last_neuron) state_nx = L2;
      L2:       if (last_neuron) state_nx = L3;
      L3:       if (last_neuron) state_nx = L4;
      L4:       if (last_neuron) state_nx = SMAX_MAX;
      SMAX_MAX: if (smax_done)   state_nx = DONE;
      default:  state_nx = IDLE;
    endcase
  end

  assign output_ready = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_cnt      <= '0;
      j_cnt      <= '0;
      fin        <= 1'b0;
      acc        <= '0;
      smax_start <= 1'b0;
      for (int i = 0; i < N_IN;  i++) in_buf[i] <= '0;
      for (int i = 0; i < N_H1;  i++) act0[i]   <= '0;
      for (int i = 0; i < N_H2;  i++) act1[i]   <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        logit[i]       <= '0;
        output_data[i] <= '0;
      end
    end else begin
      smax_start <= 1'b0;
      case (state)
        IDLE, DONE: if (input_ready) begin
          in_buf <= input_data;
          i_cnt  <= '0;
          j_cnt  <= '0;
          fin    <= 1'b0;
          acc    <= '0;
        end
        L1, L2, L3, L4: begin
          if (!fin) begin
            acc <= acc + ACC_W'(mprod);
            if (i_cnt == n_in_m1) fin   <= 1'b1;
            else                  i_cnt <= i_cnt + 6'd1;
          end else begin
            case (state)
              L1:      act0[j_cnt]        <= nres;
              L2:      act1[j_cnt[4:0]]   <= nres;
              L3:      act0[j_cnt[4:0]]   <= nres;
              default: logit[j_cnt[2:0]]  <= nres;
            endcase
            acc   <= '0;
            i_cnt <= '0;
            fin   <= 1'b0;
            j_cnt <= (j_cnt == n_out_m1) ? 6'd0 : j_cnt + 6'd1;
            if (state == L4 && j_cnt == n_out_m1) smax_start <= 1'b1;
          end
        end
        SMAX_MAX: if (smax_done) output_data <= smax_out;
        default: ;
      endcase
    end
  end

  waiz_softmax #(.WIDTH(WIDTH), .NFRAC(NFRAC)) u_softmax (
    .clk    (clk),
    .reset  (reset),
    .start  (smax_start),
    .logits (logit),
    .done   (smax_done),
    .probs  (smax_out)
  );

endmodule

`default_nettype wire

// File: tb/tb_waiz_benchmark.sv
// ============================================================================
// tb_waiz_benchmark
// Self-checking bench: integer reference network computed with plain
// arithmetic, directed corner vectors plus $urandom feature vectors.
// ============================================================================
`default_nettype none

module tb_waiz_benchmark;
  import waiz_pkg::*;

  typedef int vec16_t [16];
  typedef int vec5_t  [5];

  logic               clk = 1'b0;
  logic               reset;
  logic               input_ready;
  logic signed [15:0] input_data  [0:15];
  logic        [15:0] output_data [0:4];
  logic               output_ready;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  waiz_benchmark dut (
    .clk          (clk),
    .reset        (reset),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clip(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference network: each layer as nested sums over the parameter tables.
  function automatic void golden(input vec16_t x, output vec5_t p);
    int     sizes [5];
    longint cur [64];
    longint nxt [64];
    longint acc, y, z, m, d, sum;
    longint e [5];
    longint one;
    one   = longint'(1) << DEF_NFRAC;
    sizes = '{N_IN, N_H1, N_H2, N_H3, N_OUT};
    for (int i = 0; i < 64; i++) begin cur[i] = 0; nxt[i] = 0; end
    for (int i = 0; i < 16; i++) cur[i] = x[i];
    for (int l = 0; l < 4; l++) begin
      for (int j = 0; j < sizes[l+1]; j++) begin
        acc = 0;
        for (int i = 0; i < sizes[l]; i++)
          acc += cur[i] * longint'(dense_weight(2'(l), 7'(i), 7'(j)));
        y = clip(fdiv(acc + one * longint'(dense_bias(2'(l), 7'(j))), one));
        z = clip(fdiv(y * longint'(bn_gamma(2'(l), 7'(j))), one));
        z = clip(z + longint'(bn_beta(2'(l), 7'(j))));
        if (l < 3 && z < 0) z = 0;
        nxt[j] = z;
      end
      cur = nxt;
    end
    m = cur[0];
    for (int i = 1; i < 5; i++) if (cur[i] > m) m = cur[i];
    sum = 0;
    for (int i = 0; i < 5; i++) begin
      d = (m - cur[i]) / (longint'(1) << (DEF_NFRAC - 7));
      if (d > 1023) d = 1023;
      e[i] = longint'(exp_lut(10'(d)));
      sum += e[i];
    end
    for (int i = 0; i < 5; i++) p[i] = int'((e[i] * one) / sum);
  endfunction

  task automatic apply_reset();
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  // Start one inference; optionally re-pulse input_ready or assert reset
  // after a given number of cycles.
  task automatic run_vec(input vec16_t x, input string name,
                         input int pulse_at, input int reset_at);
    vec5_t exp_p;
    int    n;
    bit    seen;
    int    s;
    golden(x, exp_p);
    for (int k = 0; k < 16; k++) input_data[k] = 16'(x[k]);
    input_ready = 1'b1;
    @(posedge clk); #1;
    input_ready = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 5000) begin
      @(posedge clk); n++; #1;
      input_ready = (n == pulse_at);
      if (n == reset_at) begin
        reset = 1'b0;
        #1;
        check({name, "_abort_ready"}, output_ready, 0);
        for (int k = 0; k < 5; k++) check({name, "_abort_out"}, output_data[k], 0);
        @(negedge clk); reset = 1'b1;
        return;
      end
      if (output_ready) seen = 1'b1;
    end
    input_ready = 1'b0;
    check({name, "_latency"}, n, LATENCY);
    if (seen) begin
      s = 0;
      for (int k = 0; k < 5; k++) begin
        check($sformatf("%s_out%0d", name, k), output_data[k], exp_p[k]);
        s += int'(output_data[k]);
      end
      check({name, "_sum_range"}, (s >= 1019 && s <= 1024), 1);
    end
  endtask

  initial begin
    vec16_t v_spec, v_zero, v_max, v_min, v;
    logic [15:0] held [0:4];
    int bad;

    v_spec = '{-304, 378, 253, -8, 123, 14, -399, -144,
               -399, -629, -664, -537, -586, -376, 284, 430};
    for (int k = 0; k < 16; k++) begin
      v_zero[k] = 0; v_max[k] = 32767; v_min[k] = -32768;
      input_data[k] = '0;
    end
    reset = 1'b0;
    input_ready = 1'b0;

    repeat (3) @(posedge clk); #1;
    check("reset_ready", output_ready, 0);
    for (int k = 0; k < 5; k++) check("reset_out", output_data[k], 0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    run_vec(v_spec, "spec", -1, -1);

    apply_reset();
    run_vec(v_zero, "zero", -1, -1);
    for (int k = 0; k < 5; k++) held[k] = output_data[k];
    bad = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (!output_ready) bad++;
      for (int k = 0; k < 5; k++) if (output_data[k] !== held[k]) bad++;
    end
    check("zero_hold_100", bad, 0);

    apply_reset();
    run_vec(v_max, "all_max", -1, -1);
    apply_reset();
    run_vec(v_min, "all_min", -1, -1);

    apply_reset();
    run_vec(v_spec, "repulse", 100, -1);

    apply_reset();
    run_vec(v_spec, "abort", -1, 2000);
    for (int k = 0; k < 16; k++) v[k] = int'($urandom_range(0, 2047)) - 1024;
    run_vec(v, "after_abort", -1, -1);

    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 16; k++) begin
        if ($urandom_range(0, 7) == 0) v[k] = int'($urandom_range(0, 65535)) - 32768;
        else                           v[k] = int'($urandom_range(0, 4095)) - 2048;
      end
      apply_reset();
      run_vec(v, $sformatf("rand%0d", r), -1, -1);
    end

    // Restart straight from DONE without a reset.
    for (int k = 0; k < 16; k++) v[k] = int'($urandom_range(0, 2047)) - 1024;
    @(negedge clk);
    run_vec(v, "from_done", -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
